// File: rtl/quad_edge_drawer_if.sv
`default_nettype none
// =============================================================================
// Module      : quad_edge_drawer_if
// Description : Vertex command and pixel stream bundle between the vertex
//               loader, the quad edge drawer and the framebuffer writer.
// Revision    : 1.0 - initial release
// =============================================================================
interface quad_edge_drawer_if #(
  parameter int COORD_W = 10
);
  logic               draw_lines;
  logic [COORD_W-1:0] x0, y0, x1, y1, x2, y2, x3, y3;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               pix_valid;
  logic               pix_ready;
  logic               busy;
  logic               line_done;

  // Environment side: loader strobes vertices, framebuffer returns ready.
  modport master (
    output draw_lines, x0, y0, x1, y1, x2, y2, x3, y3, pix_ready,
    input  pix_x, pix_y, pix_valid, busy, line_done
  );

  // Drawer side.
  modport slave (
    input  draw_lines, x0, y0, x1, y1, x2, y2, x3, y3, pix_ready,
    output pix_x, pix_y, pix_valid, busy, line_done
  );
endinterface
`default_nettype wire

// File: rtl/quad_edge_drawer.sv
`default_nettype none
// =============================================================================
// Module      : quad_edge_drawer
// Description : Rasterises a latched quad outline edge by edge with integer
//               Bresenham onto a valid/ready pixel stream. Define
//               QUAD_CLOSE_EDGE_EN to draw the closing edge 3->0.
// Revision    : 1.0 - initial release
// =============================================================================
module quad_edge_drawer #(
  parameter int COORD_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  quad_edge_drawer_if.slave bus
);

  localparam int c_ERR_W = COORD_W + 2;
  localparam int c_E2_W  = COORD_W + 3;
  localparam logic [COORD_W-1:0] c_ONE = COORD_W'(1);
`ifdef QUAD_CLOSE_EDGE_EN
  localparam logic [1:0] c_LAST_EDGE = 2'd3;
`else
  localparam logic [1:0] c_LAST_EDGE = 2'd2;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PLOT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [COORD_W-1:0]        r_vx [4];
  logic [COORD_W-1:0]        r_vy [4];
  logic [1:0]                r_edge;
  logic [COORD_W-1:0]        r_cur_x;
  logic [COORD_W-1:0]        r_cur_y;
  logic [COORD_W-1:0]        r_end_x;
  logic [COORD_W-1:0]        r_end_y;
  logic signed [c_ERR_W-1:0] r_dx;
  logic signed [c_ERR_W-1:0] r_dy;
  logic signed [c_ERR_W-1:0] r_err;
  logic                      r_sx_neg;
  logic                      r_sy_neg;

  logic [1:0]                w_edge_b;
  logic [COORD_W-1:0]        w_ax, w_ay, w_bx, w_by;
  logic [COORD_W-1:0]        w_abs_dx, w_abs_dy;
  logic signed [c_ERR_W-1:0] w_dx, w_dy;
  logic signed [c_E2_W-1:0]  w_e2, w_dx_ext, w_dy_ext;
  logic                      w_step_x, w_step_y;
  logic signed [c_ERR_W-1:0] w_err_nxt;
  logic [COORD_W-1:0]        w_x_nxt, w_y_nxt;
  logic                      w_at_end;
  logic                      w_accept;

  // Edge endpoints: the 2-bit index wraps 3 -> 0 for the closing edge.
  assign w_edge_b = r_edge + 2'd1;
  assign w_ax     = r_vx[r_edge];
  assign w_ay     = r_vy[r_edge];
  assign w_bx     = r_vx[w_edge_b];
  assign w_by     = r_vy[w_edge_b];

  assign w_abs_dx = (w_bx > w_ax) ? (w_bx - w_ax) : (w_ax - w_bx);
  assign w_abs_dy = (w_by > w_ay) ? (w_by - w_ay) : (w_ay - w_by);
  assign w_dx     = $signed({2'b00, w_abs_dx});
  assign w_dy     = -$signed({2'b00, w_abs_dy});

  assign w_e2     = $signed({r_err, 1'b0});
  assign w_dx_ext = {r_dx[c_ERR_W-1], r_dx};
  assign w_dy_ext = {r_dy[c_ERR_W-1], r_dy};
  assign w_step_x = (w_e2 >= w_dy_ext);
  assign w_step_y = (w_e2 <= w_dx_ext);

  assign w_at_end = (r_cur_x == r_end_x) && (r_cur_y == r_end_y);
  assign w_accept = (r_state == ST_PLOT) && bus.pix_ready;

  // Both axis decisions are taken from the same pre-update e2.
  always_comb begin
    w_err_nxt = r_err;
    w_x_nxt   = r_cur_x;
    w_y_nxt   = r_cur_y;
    if (w_step_x) begin
      w_err_nxt = w_err_nxt + r_dy;
      w_x_nxt   = r_sx_neg ? (r_cur_x - c_ONE) : (r_cur_x + c_ONE);
    end
    if (w_step_y) begin
      w_err_nxt = w_err_nxt + r_dx;
      w_y_nxt   = r_sy_neg ? (r_cur_y - c_ONE) : (r_cur_y + c_ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.pix_valid = 1'b0;
    bus.busy      = 1'b1;
    bus.line_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.busy = 1'b0;
        if (bus.draw_lines) begin
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_PLOT;
      end
      ST_PLOT: begin
        bus.pix_valid = 1'b1;
        if (w_accept && w_at_end) begin
          w_state_nxt = (r_edge == c_LAST_EDGE) ? ST_DONE : ST_SETUP;
        end
      end
      ST_DONE: begin
        bus.line_done = 1'b1;
        w_state_nxt   = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vx     <= '{default: '0};
      r_vy     <= '{default: '0};
      r_edge   <= 2'd0;
      r_cur_x  <= '0;
      r_cur_y  <= '0;
      r_end_x  <= '0;
      r_end_y  <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_err    <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.draw_lines) begin
            r_vx[0] <= bus.x0;
            r_vy[0] <= bus.y0;
            r_vx[1] <= bus.x1;
            r_vy[1] <= bus.y1;
            r_vx[2] <= bus.x2;
            r_vy[2] <= bus.y2;
            r_vx[3] <= bus.x3;
            r_vy[3] <= bus.y3;
            r_edge  <= 2'd0;
          end
        end
        ST_SETUP: begin
          r_cur_x  <= w_ax;
          r_cur_y  <= w_ay;
          r_end_x  <= w_bx;
          r_end_y  <= w_by;
          r_dx     <= w_dx;
          r_dy     <= w_dy;
          r_err    <= w_dx + w_dy;
          r_sx_neg <= !(w_bx > w_ax);
          r_sy_neg <= !(w_by > w_ay);
        end
        ST_PLOT: begin
          if (w_accept) begin
            if (w_at_end) begin
              r_edge <= r_edge + 2'd1;
            end else begin
              r_cur_x <= w_x_nxt;
              r_cur_y <= w_y_nxt;
              r_err   <= w_err_nxt;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.pix_x = r_cur_x;
  assign bus.pix_y = r_cur_y;

endmodule
`default_nettype wire

// File: tb/tb_quad_edge_drawer.sv
`default_nettype none
// =============================================================================
// Module      : tb_quad_edge_drawer
// Description : Self-checking bench for quad_edge_drawer (edge count follows
//               QUAD_CLOSE_EDGE_EN).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_quad_edge_drawer;

  localparam int COORD_W = 10;
`ifdef QUAD_CLOSE_EDGE_EN
  localparam int N_EDGES = 4;
`else
  localparam int N_EDGES = 3;
`endif
  localparam int MAX_CYC = 6000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  quad_edge_drawer_if #(.COORD_W(COORD_W)) bus ();

  quad_edge_drawer #(.COORD_W(COORD_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int x;
    int y;
  } pix_t;

  typedef struct {
    string name;
    int x0, y0, x1, y1, x2, y2, x3, y3;
    int px4, done4, px3, done3;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  pix_t exp_q[$];
  int   cur_vx[4];
  int   cur_vy[4];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: plain-integer Bresenham over the vertex list.
  function automatic void build_model();
    exp_q.delete();
    for (int e = 0; e < N_EDGES; e++) begin
      int ax, ay, bx, by, x, y, dx, dy, sx, sy, err, e2, guard;
      ax = cur_vx[e];           ay = cur_vy[e];
      bx = cur_vx[(e + 1) % 4]; by = cur_vy[(e + 1) % 4];
      x = ax; y = ay;
      dx = (bx > ax) ? bx - ax : ax - bx;
      dy = (by > ay) ? ay - by : by - ay;
      sx = (bx > ax) ? 1 : -1;
      sy = (by > ay) ? 1 : -1;
      err = dx + dy;
      guard = 0;
      while (guard < 4000) begin
        pix_t p;
        p.x = x; p.y = y;
        exp_q.push_back(p);
        if (x == bx && y == by) break;
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; x += sx; end
        if (e2 <= dx) begin err += dx; y += sy; end
        guard++;
      end
    end
  endfunction

  task automatic drive_verts(input bit scramble);
    if (scramble) begin
      bus.x0 = COORD_W'($urandom); bus.y0 = COORD_W'($urandom);
      bus.x1 = COORD_W'($urandom); bus.y1 = COORD_W'($urandom);
      bus.x2 = COORD_W'($urandom); bus.y2 = COORD_W'($urandom);
      bus.x3 = COORD_W'($urandom); bus.y3 = COORD_W'($urandom);
    end else begin
      bus.x0 = COORD_W'(cur_vx[0]); bus.y0 = COORD_W'(cur_vy[0]);
      bus.x1 = COORD_W'(cur_vx[1]); bus.y1 = COORD_W'(cur_vy[1]);
      bus.x2 = COORD_W'(cur_vx[2]); bus.y2 = COORD_W'(cur_vy[2]);
      bus.x3 = COORD_W'(cur_vx[3]); bus.y3 = COORD_W'(cur_vy[3]);
    end
  endtask

  // Cycle 0 carries the strobe; later cycles are counted from it.
  task automatic run_draw(input int ready_pct, input bit inject,
                          output int first_c, output int done_c,
                          output int npix, output int exp_total);
    bit   prev_stall;
    bit   rdy;
    int   hold_x, hold_y;
    pix_t p;
    build_model();
    exp_total  = exp_q.size();
    first_c    = -1;
    done_c     = -1;
    npix       = 0;
    prev_stall = 1'b0;
    hold_x     = 0;
    hold_y     = 0;
    @(negedge clk);
    drive_verts(1'b0);
    bus.draw_lines = 1'b1;
    bus.pix_ready  = 1'b1;
    for (int c = 1; c <= MAX_CYC; c++) begin
      @(negedge clk);
      drive_verts(1'b1);
      bus.draw_lines = inject && (c % 7 == 3);
      if (prev_stall) begin
        check("stall_valid", int'(bus.pix_valid), 1);
        check("stall_x", int'(bus.pix_x), hold_x);
        check("stall_y", int'(bus.pix_y), hold_y);
      end
      check("busy_during_draw", int'(bus.busy), 1);
      if (bus.line_done) begin
        done_c = c;
        bus.draw_lines = 1'b0;
        break;
      end
      rdy = ($urandom_range(99) < ready_pct);
      bus.pix_ready = rdy;
      prev_stall = bus.pix_valid && !rdy;
      if (bus.pix_valid) begin
        if (first_c < 0) first_c = c;
        hold_x = int'(bus.pix_x);
        hold_y = int'(bus.pix_y);
        if (rdy) begin
          npix++;
          if (exp_q.size() == 0) begin
            check("pixel_overrun", npix, exp_total);
          end else begin
            p = exp_q.pop_front();
            check("pix_x", hold_x, p.x);
            check("pix_y", hold_y, p.y);
          end
        end
      end
    end
    if (done_c < 0) check("line_done_timeout", done_c, 0);
    check("pixels_missing", exp_q.size(), 0);
    bus.pix_ready = 1'b1;
    @(negedge clk);
    check("post_done_busy", int'(bus.busy), 0);
    check("post_done_line_done", int'(bus.line_done), 0);
    check("post_done_valid", int'(bus.pix_valid), 0);
  endtask

  vec_t vecs[4];
  int   first_c, done_c, npix, exp_total;

  initial begin
    vecs[0] = '{"square", 10, 10, 20, 10, 20, 20, 10, 20, 44, 49, 33, 37};
    vecs[1] = '{"degenerate", 5, 5, 5, 5, 5, 5, 5, 5, 4, 9, 3, 7};
    vecs[2] = '{"diagonal", 10, 20, 30, 40, 30, 20, 10, 40, 84, 89, 63, 67};
    vecs[3] = '{"steep", 0, 0, 80, 333, 100, 5, 7, 200, 1060, 1065, 859, 863};

    bus.draw_lines = 1'b0;
    bus.pix_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cur_vx[i] = 0;
      cur_vy[i] = 0;
    end
    drive_verts(1'b0);
    repeat (3) @(negedge clk);
    check("reset_valid", int'(bus.pix_valid), 0);
    check("reset_x", int'(bus.pix_x), 0);
    check("reset_y", int'(bus.pix_y), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_line_done", int'(bus.line_done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors: full-rate, backpressured, and with stray strobes.
    for (int v = 0; v < 4; v++) begin
      cur_vx = '{vecs[v].x0, vecs[v].x1, vecs[v].x2, vecs[v].x3};
      cur_vy = '{vecs[v].y0, vecs[v].y1, vecs[v].y2, vecs[v].y3};
      for (int mode = 0; mode < 3; mode++) begin
        run_draw((mode == 1) ? 50 : 100, mode == 2, first_c, done_c, npix, exp_total);
        check({vecs[v].name, "_count"}, npix, (N_EDGES == 4) ? vecs[v].px4 : vecs[v].px3);
        if (mode != 1) begin
          check({vecs[v].name, "_first"}, first_c, 2);
          check({vecs[v].name, "_done"}, done_c,
                (N_EDGES == 4) ? vecs[v].done4 : vecs[v].done3);
        end
      end
    end

    // Random quads against the reference model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) begin
        cur_vx[i] = int'($urandom_range(255));
        cur_vy[i] = int'($urandom_range(255));
      end
      run_draw((r % 2 == 0) ? 100 : 60, r == 3, first_c, done_c, npix, exp_total);
      check("rand_count", npix, exp_total);
      if (r % 2 == 0) check("rand_done", done_c, 1 + exp_total + N_EDGES);
    end

    // Asynchronous reset in the middle of an edge.
    cur_vx = '{10, 20, 20, 10};
    cur_vy = '{10, 10, 20, 20};
    @(negedge clk);
    drive_verts(1'b0);
    bus.draw_lines = 1'b1;
    bus.pix_ready  = 1'b1;
    @(negedge clk);
    bus.draw_lines = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_valid", int'(bus.pix_valid), 1);
    rst_n = 1'b0;
    #1;
    check("midreset_valid", int'(bus.pix_valid), 0);
    check("midreset_busy", int'(bus.busy), 0);
    check("midreset_x", int'(bus.pix_x), 0);
    @(negedge clk);
    check("midreset_hold_valid", int'(bus.pix_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_draw(100, 1'b0, first_c, done_c, npix, exp_total);
    check("after_reset_count", npix, (N_EDGES == 4) ? 44 : 33);
    check("after_reset_done", done_c, (N_EDGES == 4) ? 49 : 37);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
